// File: rtl/mem_self_test.sv
// Memory self-test sequencer: writes a pattern over an address window through
// memCtrl, reads it back, and reports pass, first mismatch or command timeout.
module mem_self_test #(
  parameter int unsigned        ADDR_W     = 16,
  parameter int unsigned        BANK_W     = 7,
  parameter int unsigned        DATA_W     = 8,
  parameter logic [ADDR_W-1:0]  START_ADDR = 16'hC000,
  parameter logic [ADDR_W-1:0]  END_ADDR   = 16'hC0FF,
  parameter int unsigned        TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic              busy,
  input  logic [DATA_W-1:0] dataRead,
  output logic              CE,
  output logic              write,
  output logic [BANK_W-1:0] bank,
  output logic [ADDR_W-1:0] addrBus,
  output logic [DATA_W-1:0] dataToWrite,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [3:0]        color
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] COLOR_BLACK  = 4'd0;
  localparam logic [3:0] COLOR_RED    = 4'd1;
  localparam logic [3:0] COLOR_GREEN  = 4'd2;
  localparam logic [3:0] COLOR_YELLOW = 4'd3;
  localparam logic [3:0] COLOR_BLUE   = 4'd5;

  typedef enum logic [3:0] {
    IDLE, WR_ISSUE, WR_ACK, WR_WAIT, RD_ISSUE, RD_ACK, RD_WAIT,
    CHECK, PASS, FAIL, TOUT
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [1:0]         mode_q;
  logic [BANK_W-1:0]  bank_q;
  logic [CNT_W-1:0]   tcnt;
  logic [DATA_W-1:0]  capture;
  logic [DATA_W-1:0]  pat_c;

  // Expected data word for an address under the latched mode and bank.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [BANK_W-1:0] b);
    case (m)
      2'd0:    return '0;
      2'd1:    return '1;
      2'd2:    return DATA_W'(a) ^ DATA_W'(b);
      default: return ~(DATA_W'(a));
    endcase
  endfunction

  assign pat_c = pattern(mode_q, addr, bank_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      mode_q      <= '0;
      bank_q      <= '0;
      tcnt        <= '0;
      capture     <= '0;
      CE          <= 1'b0;
      write       <= 1'b0;
      bank        <= '0;
      addrBus     <= '0;
      dataToWrite <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      fail_exp    <= '0;
      fail_got    <= '0;
      color       <= COLOR_BLACK;
    end else begin
      CE <= 1'b0;
      case (state)
        IDLE, PASS, FAIL, TOUT: begin
          if (start) begin
            mode_q    <= mode;
            bank_q    <= bank_sel;
            addr      <= START_ADDR;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
            color     <= COLOR_YELLOW;
            state     <= WR_ISSUE;
          end
        end
        // Command fields are loaded with CE and then held until the next CE.
        WR_ISSUE, RD_ISSUE: begin
          if (!busy) begin
            CE          <= 1'b1;
            write       <= (state == WR_ISSUE);
            addrBus     <= addr;
            bank        <= bank_q;
            dataToWrite <= pat_c;
            tcnt        <= '0;
            state       <= (state == WR_ISSUE) ? WR_ACK : RD_ACK;
          end
        end
        WR_ACK, RD_ACK: begin
          if (busy) begin
            state <= (state == WR_ACK) ? WR_WAIT : RD_WAIT;
          end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
            done  <= 1'b1;
            color <= COLOR_BLUE;
            state <= TOUT;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        // End-of-window test precedes the increment so the counter never wraps.
        WR_WAIT: begin
          if (!busy) begin
            if (addr == END_ADDR) begin
              addr  <= START_ADDR;
              state <= RD_ISSUE;
            end else begin
              addr  <= addr + ADDR_W'(1);
              state <= WR_ISSUE;
            end
          end
        end
        RD_WAIT: begin
          if (!busy) begin
            capture <= dataRead;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (capture != pat_c) begin
            fail_addr <= addr;
            fail_exp  <= pat_c;
            fail_got  <= capture;
            done      <= 1'b1;
            color     <= COLOR_RED;
            state     <= FAIL;
          end else if (addr == END_ADDR) begin
            done  <= 1'b1;
            pass  <= 1'b1;
            color <= COLOR_GREEN;
            state <= PASS;
          end else begin
            addr  <= addr + ADDR_W'(1);
            state <= RD_ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_self_test.sv
// Scoreboard bench for mem_self_test: two instances (C000..C003 and FFFE..FFFF)
// against a memCtrl model with ideal memory, read corruption and busy controls.
module tb_mem_self_test;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [1:0]       start, busy, busy_hold, never, corrupt_en;
  logic [1:0]       ce, wr, done, pass;
  logic [1:0][1:0]  mode;
  logic [1:0][6:0]  bank_sel, bank;
  logic [1:0][15:0] addr, fail_addr, corrupt_addr;
  logic [1:0][7:0]  dread, dw, fail_exp, fail_got;
  logic [1:0][3:0]  color;
  logic [1:0][3:0]  sched;
  logic [7:0]       mem [2][65536];

  mem_self_test #(.START_ADDR(16'hC000), .END_ADDR(16'hC003), .TIMEOUT(16)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .mode(mode[0]), .bank_sel(bank_sel[0]),
    .busy(busy[0]), .dataRead(dread[0]), .CE(ce[0]), .write(wr[0]), .bank(bank[0]),
    .addrBus(addr[0]), .dataToWrite(dw[0]), .done(done[0]), .pass(pass[0]),
    .fail_addr(fail_addr[0]), .fail_exp(fail_exp[0]), .fail_got(fail_got[0]), .color(color[0]));

  mem_self_test #(.START_ADDR(16'hFFFE), .END_ADDR(16'hFFFF), .TIMEOUT(16)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .mode(mode[1]), .bank_sel(bank_sel[1]),
    .busy(busy[1]), .dataRead(dread[1]), .CE(ce[1]), .write(wr[1]), .bank(bank[1]),
    .addrBus(addr[1]), .dataToWrite(dw[1]), .done(done[1]), .pass(pass[1]),
    .fail_addr(fail_addr[1]), .fail_exp(fail_exp[1]), .fail_got(fail_got[1]), .color(color[1]));

  // memCtrl model: busy rises one cycle after CE is seen and lasts three cycles.
  assign busy = {(|sched[1][3:1]) | busy_hold[1], (|sched[0][3:1]) | busy_hold[0]};

  always_ff @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      sched[g] <= {sched[g][2:0], ce[g] & ~never[g]};
      if (ce[g] && wr[g]) mem[g][addr[g]] <= dw[g];
      if (ce[g] && !wr[g])
        dread[g] <= (corrupt_en[g] && addr[g] == corrupt_addr[g]) ? 8'hFF : mem[g][addr[g]];
    end
  end

  typedef struct { int inst; logic w; logic [15:0] a; logic [6:0] b; logic [7:0] d; } cmd_t;
  typedef struct { int inst; logic ps; logic [3:0] col; logic [15:0] fa; logic [7:0] fe; logic [7:0] fg; } res_t;

  cmd_t cmd_q[$];
  res_t res_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ce_cnt [2] = '{0, 0};
  logic [1:0] prev_ce = '0;
  logic [1:0] prev_done = '0;

  // Monitor: every CE pops an expected command, every rising done an outcome.
  always @(negedge clk) begin
    cmd_t c;
    res_t r;
    for (int g = 0; g < 2; g++) begin
      if (ce[g]) begin
        ce_cnt[g]++;
        checks++;
        if (prev_ce[g]) begin
          errors++;
          $display("FAIL ce_single_cycle inst=%0d got CE high on consecutive cycles, required one-cycle pulse", g);
        end
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd inst=%0d got w=%0b addr=%h data=%h, required no command", g, wr[g], addr[g], dw[g]);
        end else begin
          c = cmd_q.pop_front();
          if (c.inst != g || c.w !== wr[g] || c.a !== addr[g] || c.b !== bank[g] || (c.w && c.d !== dw[g])) begin
            errors++;
            $display("FAIL cmd inst=%0d got w=%0b addr=%h bank=%h data=%h, required inst=%0d w=%0b addr=%h bank=%h data=%h",
                     g, wr[g], addr[g], bank[g], dw[g], c.inst, c.w, c.a, c.b, c.d);
          end
        end
      end
      if (done[g] && !prev_done[g]) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done inst=%0d got done=1 pass=%0b color=%0d, required no outcome", g, pass[g], color[g]);
        end else begin
          r = res_q.pop_front();
          if (r.inst != g || r.ps !== pass[g] || r.col !== color[g] || r.fa !== fail_addr[g] ||
              r.fe !== fail_exp[g] || r.fg !== fail_got[g]) begin
            errors++;
            $display("FAIL outcome inst=%0d got pass=%0b color=%0d fa=%h fe=%h fg=%h, required inst=%0d pass=%0b color=%0d fa=%h fe=%h fg=%h",
                     g, pass[g], color[g], fail_addr[g], fail_exp[g], fail_got[g], r.inst, r.ps, r.col, r.fa, r.fe, r.fg);
          end
        end
      end
      prev_ce[g]   = ce[g];
      prev_done[g] = done[g];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic push_cmd(input int g, input logic w, input logic [15:0] a, input logic [6:0] b, input logic [7:0] d);
    cmd_t c;
    c.inst = g; c.w = w; c.a = a; c.b = b; c.d = d;
    cmd_q.push_back(c);
  endtask

  task automatic push_res(input int g, input logic ps, input logic [3:0] col,
                          input logic [15:0] fa, input logic [7:0] fe, input logic [7:0] fg);
    res_t r;
    r.inst = g; r.ps = ps; r.col = col; r.fa = fa; r.fe = fe; r.fg = fg;
    res_q.push_back(r);
  endtask

  // d[i] is the data written at a0+i.
  task automatic push_run(input int g, input logic [15:0] a0, input int n_wr, input int n_rd,
                          input logic [6:0] b, input logic [3:0][7:0] d);
    for (int i = 0; i < n_wr; i++) push_cmd(g, 1'b1, a0 + 16'(i), b, d[i]);
    for (int i = 0; i < n_rd; i++) push_cmd(g, 1'b0, a0 + 16'(i), b, 8'h00);
  endtask

  // One-cycle start; mode/bank_sel are scrambled afterwards to prove they were latched.
  task automatic do_start(input int g, input logic [1:0] m, input logic [6:0] b);
    @(posedge clk); #1;
    mode[g] = m; bank_sel[g] = b; start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0; mode[g] = ~m; bank_sel[g] = ~b;
  endtask

  task automatic wait_done(input int g, input string name);
    int n = 0;
    while (!done[g] && n < 500) begin @(negedge clk); n++; end
    chk(name, 32'(done[g]), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset(input int g);
    chk("rst_ce", 32'(ce[g]), 0);           chk("rst_write", 32'(wr[g]), 0);
    chk("rst_addrBus", 32'(addr[g]), 0);    chk("rst_bank", 32'(bank[g]), 0);
    chk("rst_dataToWrite", 32'(dw[g]), 0);  chk("rst_done", 32'(done[g]), 0);
    chk("rst_pass", 32'(pass[g]), 0);       chk("rst_fail_addr", 32'(fail_addr[g]), 0);
    chk("rst_fail_exp", 32'(fail_exp[g]), 0); chk("rst_fail_got", 32'(fail_got[g]), 0);
    chk("rst_color", 32'(color[g]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, required bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    reset = 1'b1; start = '0; mode = '0; bank_sel = '0;
    busy_hold = '0; never = '0; corrupt_en = '0; corrupt_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    reset = 1'b0;

    // Mode 2, bank 0: ideal memory, full pass.
    n0 = ce_cnt[0];
    push_run(0, 16'hC000, 4, 4, 7'h00, {8'h03, 8'h02, 8'h01, 8'h00});
    push_res(0, 1'b1, 4'd2, 16'h0000, 8'h00, 8'h00);
    do_start(0, 2'd2, 7'h00);
    wait_done(0, "done_m2_b0");
    chk("ce_pulses_m2_b0", 32'(ce_cnt[0] - n0), 32'd8);
    chk("pass_m2_b0", 32'(pass[0]), 32'd1);
    chk("color_m2_b0", 32'(color[0]), 32'd2);

    // Mode 2, bank 5: XOR with the latched bank.
    push_run(0, 16'hC000, 4, 4, 7'h05, {8'h06, 8'h07, 8'h04, 8'h05});
    push_res(0, 1'b1, 4'd2, 16'h0000, 8'h00, 8'h00);
    do_start(0, 2'd2, 7'h05);
    wait_done(0, "done_m2_b5");

    // Corrupted read at C002: stop at first error, no read of C003.
    corrupt_en[0] = 1'b1; corrupt_addr[0] = 16'hC002;
    push_run(0, 16'hC000, 4, 3, 7'h00, {8'h03, 8'h02, 8'h01, 8'h00});
    push_res(0, 1'b0, 4'd1, 16'hC002, 8'h02, 8'hFF);
    do_start(0, 2'd2, 7'h00);
    wait_done(0, "done_mismatch");
    repeat (10) @(negedge clk);
    chk("cmds_left_mismatch", 32'(cmd_q.size()), 32'd0);
    chk("pass_mismatch", 32'(pass[0]), 32'd0);
    corrupt_en[0] = 1'b0;

    // busy never rises: timeout 16 cycles after CE, no further CE.
    never[0] = 1'b1;
    push_cmd(0, 1'b1, 16'hC000, 7'h00, 8'h00);
    push_res(0, 1'b0, 4'd5, 16'h0000, 8'h00, 8'h00);
    do_start(0, 2'd0, 7'h00);
    n = 0;
    while (!ce[0] && n < 50) begin @(negedge clk); n++; end
    chk("ce_seen_tout", 32'(ce[0]), 32'd1);
    n = 0;
    while (!done[0] && n < 100) begin @(negedge clk); n++; end
    chk("tout_cycles", 32'(n), 32'd16);
    repeat (20) @(negedge clk);
    chk("cmds_left_tout", 32'(cmd_q.size()), 32'd0);
    chk("color_tout", 32'(color[0]), 32'd5);
    never[0] = 1'b0;

    // busy held at launch, then a mid-run start pulse that must be ignored.
    busy_hold[0] = 1'b1;
    n0 = ce_cnt[0];
    push_run(0, 16'hC000, 4, 4, 7'h00, {8'hFC, 8'hFD, 8'hFE, 8'hFF});
    push_res(0, 1'b1, 4'd2, 16'h0000, 8'h00, 8'h00);
    do_start(0, 2'd3, 7'h00);
    repeat (5) @(negedge clk);
    chk("ce_while_busy", 32'(ce_cnt[0] - n0), 32'd0);
    chk("color_running", 32'(color[0]), 32'd3);
    busy_hold[0] = 1'b0;
    n = 0;
    while ((ce_cnt[0] - n0) < 3 && n < 200) begin @(negedge clk); n++; end
    chk("midrun_reached", 32'((ce_cnt[0] - n0) >= 3), 32'd1);
    @(posedge clk); #1; start[0] = 1'b1; mode[0] = 2'd0;
    @(posedge clk); #1; start[0] = 1'b0;
    wait_done(0, "done_midrun_start");

    // Reset during the second read's wait, then a clean mode 1 run.
    n0 = ce_cnt[0];
    push_run(0, 16'hC000, 4, 2, 7'h00, {8'h00, 8'h00, 8'h00, 8'h00});
    do_start(0, 2'd0, 7'h00);
    n = 0;
    while ((ce_cnt[0] - n0) < 6 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (!busy[0] && n < 20) begin @(negedge clk); n++; end
    chk("busy_in_rd_wait", 32'(busy[0]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset(0);
    reset = 1'b0;
    chk("cmds_left_abort", 32'(cmd_q.size()), 32'd0);
    push_run(0, 16'hC000, 4, 4, 7'h00, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
    push_res(0, 1'b1, 4'd2, 16'h0000, 8'h00, 8'h00);
    do_start(0, 2'd1, 7'h00);
    wait_done(0, "done_after_reset");

    // Window at the top of the address space: FFFE, FFFF only.
    push_run(1, 16'hFFFE, 2, 2, 7'h00, {8'h00, 8'h00, 8'h00, 8'h01});
    push_res(1, 1'b1, 4'd2, 16'h0000, 8'h00, 8'h00);
    do_start(1, 2'd3, 7'h00);
    wait_done(1, "done_top_window");
    repeat (10) @(negedge clk);
    chk("pass_top_window", 32'(pass[1]), 32'd1);

    chk("cmd_queue_empty", 32'(cmd_q.size()), 32'd0);
    chk("res_queue_empty", 32'(res_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_self_test.md
MEM_SELF_TEST -- requirements
Module: mem_self_test

Interface
REQ-001 Parameter ADDR_W, 16, width of the memCtrl address bus.
REQ-002 Parameter BANK_W, 7, width of the memCtrl bank select.
REQ-003 Parameter DATA_W, 8, width of the data word.
REQ-004 Parameter START_ADDR, 16'hC000, first address tested (inclusive).
REQ-005 Parameter END_ADDR, 16'hC0FF, last address tested (inclusive); START_ADDR <= END_ADDR.
REQ-006 Parameter TIMEOUT, 1024, maximum clk cycles allowed for busy to rise after a CE pulse.
REQ-007 Port clk input 1: single clock; memCtrl runs on the same clock.
REQ-008 Port reset input 1: synchronous, active-high reset.
REQ-009 Port start input 1: a level-high sample in IDLE launches a test run.
REQ-010 Port mode input 2: pattern select; 0 = all 0x00, 1 = all ones, 2 = addr[DATA_W-1:0] XOR bank, 3 = ~addr[DATA_W-1:0].
REQ-011 Port bank_sel input BANK_W: bank under test; sampled at start.
REQ-012 Port busy input 1: memCtrl busy.
REQ-013 Port dataRead input DATA_W: memCtrl read data; valid when busy falls after a read.
REQ-014 Port CE output 1: memCtrl command strobe.
REQ-015 Port write output 1: 1 = write command, 0 = read command; qualified by CE.
REQ-016 Port bank output BANK_W; Port addrBus output ADDR_W; Port dataToWrite output DATA_W: command fields, qualified by CE.
REQ-017 Port done output 1: run finished (any outcome); held until the next start or reset.
REQ-018 Port pass output 1: run finished without mismatch or timeout.
REQ-019 Port fail_addr output ADDR_W; Port fail_exp output DATA_W; Port fail_got output DATA_W: first mismatch record.
REQ-020 Port color output 4: status; 0 black idle, 3 yellow running, 2 green pass, 1 red mismatch, 5 blue timeout.

Function
REQ-021 States are IDLE, WR_ISSUE, WR_ACK, WR_WAIT, RD_ISSUE, RD_ACK, RD_WAIT, CHECK, PASS, FAIL, TOUT.
REQ-022 IDLE: when start=1, latch mode and bank_sel, set address counter to START_ADDR, clear done, pass and fail_*, go to WR_ISSUE; start in any other state is ignored.
REQ-023 WR_ISSUE/RD_ISSUE: while busy=1, hold without asserting CE; when busy=0, assert CE for exactly one cycle with write, addrBus, bank and dataToWrite valid in that same cycle, then go to *_ACK.
REQ-024 CE is never high for two consecutive cycles; write, addrBus, bank and dataToWrite hold their values from the CE cycle until the next CE.
REQ-025 *_ACK: busy=1 moves to *_WAIT; the timeout counter, cleared at CE, increments each cycle; if it reaches TIMEOUT without busy rising, go to TOUT.
REQ-026 *_WAIT: busy=0 ends the command; busy=1 in the same cycle as the state entry is legal and does not end the command.
REQ-027 Write pass: after WR_WAIT completes, if addr==END_ADDR set addr=START_ADDR and go to RD_ISSUE, else addr+1 and go to WR_ISSUE.
REQ-028 The end test is an equality compare before increment; the counter never wraps, including when END_ADDR = 2^ADDR_W-1.
REQ-029 RD_WAIT completion captures dataRead in the cycle busy is low, then goes to CHECK.
REQ-030 CHECK: compare the capture with the mode pattern for addr; on mismatch latch addr, expected and captured into fail_*, then go to FAIL (the run stops at the first error); on match, go to PASS at END_ADDR, else addr+1 and go to RD_ISSUE.
REQ-031 The mode pattern is computed from the latched mode and bank, truncated or zero-extended to DATA_W.
REQ-032 PASS/FAIL/TOUT set done=1; pass=1 only in PASS; outcome is held; start=1 returns to the IDLE launch behaviour (REQ-022) directly.
REQ-033 color is registered: yellow in every running state and green/red/blue in PASS/FAIL/TOUT.
REQ-034 START_ADDR == END_ADDR gives exactly one write and one read.

Reset
REQ-035 reset=1 at a clock edge forces IDLE, CE=0, write=0, addrBus=0, bank=0, dataToWrite=0, done=0, pass=0, fail_*=0, color=0, counters=0, including mid-command; any busy still pending from memCtrl is ignored until the next start.

Verification
REQ-036 START=C000, END=C003, mode 2, bank 0, model busy 1 cycle after CE for 3 cycles with ideal memory -> 4 writes of 00,01,02,03 then 4 reads, pass=1, color=2, CE pulses=8.
REQ-037 Same setup, model corrupts C002 read to 0xFF -> done=1, pass=0, fail_addr=C002, fail_exp=02, fail_got=FF, color=1, no read of C003.
REQ-038 busy never rises after the first CE, TIMEOUT=16 -> TOUT after 16 cycles, color=5, CE never reasserted.
REQ-039 END=FFFF, START=FFFE, mode 3 -> addresses FFFE,FFFF only, no access to 0000, pass=1.
REQ-040 reset=1 during RD_WAIT of the second read, then start with mode 1 -> all outputs at reset values the next cycle, then a clean full run passes with data FF.
REQ-041 busy held high at start for 5 cycles -> no CE until busy=0; start pulsed mid-run -> ignored.
